// File: rtl/mini_alu_pkg.sv
// mini_alu_pipe shared types: opcodes, FSM states, field positions.
// Imported by the core and its sub-units.
package mini_alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LED = 4'd1,
    OP_BLE = 4'd2,
    OP_STO = 4'd3,
    OP_ADD = 4'd4,
    OP_JMP = 4'd5,
    OP_SUB = 4'd6,
    OP_MUL = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9,
    OP_BEQ = 4'd10,
    OP_HLT = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_BUSY = 2'd1,
    HALTED   = 2'd2
  } state_e;

  localparam int OP_BITS = 4;

  function automatic int instrWidth(int aw);
    return OP_BITS + 3 * aw;
  endfunction

  function automatic int src1Lsb(int aw);
    return aw;
  endfunction

  function automatic int dstLsb(int aw);
    return 2 * aw;
  endfunction

  function automatic int opLsb(int aw);
    return 3 * aw;
  endfunction

endpackage

// File: rtl/mini_alu_if.sv
// Instruction ROM bus: the core drives the address, the ROM
// answers combinationally in the same cycle.
interface mini_alu_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int IP_WIDTH   = 16
);
  logic [IP_WIDTH-1:0]       oIAddress;
  logic [3+3*ADDR_WIDTH:0]   iInstruction;

  modport master (
    output oIAddress,
    input  iInstruction
  );

  modport slave (
    input  oIAddress,
    output iInstruction
  );
endinterface

// File: rtl/mini_alu_pipe_mul.sv
// Iterative shift-add multiplier, one partial product per clock.
// The final sum is combinational so the caller can write it on done.
module seq_multiplier #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] partial;
  logic [CW-1:0]         cnt;

  always_comb begin
    partial = acc;
    if (mplier[0]) partial = acc + mcand;
  end

  assign done    = busy && (cnt == CW'(DATA_WIDTH - 1));
  assign product = partial;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start && !busy) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      acc    <= partial;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/mini_alu_pipe.sv
// Two-stage fetch/execute register machine with bypass,
// one-bubble branches, stalling iterative MUL and halt.
module mini_alu_pipe
  import mini_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int IP_WIDTH   = 16,
  parameter int LED_WIDTH  = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  mini_alu_if.master           rom,
  output logic [LED_WIDTH-1:0] oLed,
  output logic                 oBusy,
  output logic                 oHalted
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int S1L = src1Lsb(ADDR_WIDTH);
  localparam int DL  = dstLsb(ADDR_WIDTH);
  localparam int OPL = opLsb(ADDR_WIDTH);

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] reg_t;

  state_e              state, stateNext;
  logic [IP_WIDTH-1:0] ip;
  opcode_e             exOp;
  reg_t                exDst, exSrc1, exSrc0;
  word_t               exA, exB;
  word_t               regs [2**ADDR_WIDTH];

  logic [3:0] fOp;
  reg_t       fDst, fSrc1, fSrc0;
  word_t      rdA, rdB;

  word_t aluRes, wrData, mulRes;
  logic  aluWr, wrEn, taken, ledEn;
  logic  run, fetch, mulStart, mulBusy, mulDone;

  assign fOp   = rom.iInstruction[OPL +: OP_BITS];
  assign fDst  = rom.iInstruction[DL +: ADDR_WIDTH];
  assign fSrc1 = rom.iInstruction[S1L +: ADDR_WIDTH];
  assign fSrc0 = rom.iInstruction[ADDR_WIDTH-1:0];

  assign rom.oIAddress = ip;
  assign oBusy         = (state == MUL_BUSY);
  assign oHalted       = (state == HALTED);
  assign run           = (state == RUN);

  always_comb begin
    aluRes = '0;
    aluWr  = 1'b0;
    taken  = 1'b0;
    ledEn  = 1'b0;
    case (exOp)
      OP_ADD: begin aluRes = exA + exB; aluWr = 1'b1; end
      OP_SUB: begin aluRes = exA - exB; aluWr = 1'b1; end
      OP_STO: begin
        aluRes = DATA_WIDTH'({exSrc1, exSrc0});
        aluWr  = 1'b1;
      end
      OP_SHL: begin
        aluRes = exA << exB[SHW-1:0];
        aluWr  = 1'b1;
      end
      OP_SHR: begin
        aluRes = exA >> exB[SHW-1:0];
        aluWr  = 1'b1;
      end
      OP_LED: ledEn = 1'b1;
      OP_JMP: taken = 1'b1;
      OP_BLE: taken = (exA <= exB);
      OP_BEQ: taken = (exA == exB);
      default: ;
    endcase
  end

  // MUL result lands on the last iteration edge, same as an ALU write
  assign mulStart = run && (exOp == OP_MUL);
  assign wrEn     = (run && aluWr) || mulDone;
  assign wrData   = mulDone ? mulRes : aluRes;
  assign fetch    = (run && exOp != OP_MUL && exOp != OP_HLT)
                 || mulDone;

  assign rdA = (wrEn && exDst == fSrc1) ? wrData : regs[fSrc1];
  assign rdB = (wrEn && exDst == fSrc0) ? wrData : regs[fSrc0];

  always_comb begin
    stateNext = state;
    unique case (state)
      RUN: begin
        if (exOp == OP_MUL)      stateNext = MUL_BUSY;
        else if (exOp == OP_HLT) stateNext = HALTED;
      end
      MUL_BUSY: if (mulDone) stateNext = RUN;
      HALTED:   stateNext = HALTED;
      default:  stateNext = RUN;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state  <= RUN;
      ip     <= '0;
      exOp   <= OP_NOP;
      exDst  <= '0;
      exSrc1 <= '0;
      exSrc0 <= '0;
      exA    <= '0;
      exB    <= '0;
      oLed   <= '0;
    end else begin
      state <= stateNext;
      if (run && ledEn) oLed <= exA[LED_WIDTH-1:0];
      if (run && taken) begin
        ip   <= IP_WIDTH'(exDst);
        exOp <= OP_NOP;
      end else if (fetch) begin
        ip     <= ip + IP_WIDTH'(1);
        exOp   <= opcode_e'(fOp);
        exDst  <= fDst;
        exSrc1 <= fSrc1;
        exSrc0 <= fSrc0;
        exA    <= rdA;
        exB    <= rdB;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (wrEn) regs[exDst] <= wrData;
  end

  seq_multiplier #(.DATA_WIDTH(DATA_WIDTH)) uMul (
    .Clock   (Clock),
    .Reset   (Reset),
    .start   (mulStart),
    .a       (exA),
    .b       (exB),
    .busy    (mulBusy),
    .done    (mulDone),
    .product (mulRes)
  );

  logic unusedBusy;
  assign unusedBusy = mulBusy;

endmodule

// File: tb/tb_mini_alu_pipe.sv
// Directed program tests for mini_alu_pipe at default width
// and at DATA_WIDTH=8 / ADDR_WIDTH=4.
module tb_mini_alu_pipe;
  import mini_alu_pkg::*;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic ResetA, ResetB;
  logic [7:0] ledA, ledB;
  logic busyA, busyB, haltA, haltB;

  mini_alu_if #(.ADDR_WIDTH(8), .IP_WIDTH(16)) busA ();
  mini_alu_if #(.ADDR_WIDTH(4), .IP_WIDTH(16)) busB ();

  logic [27:0] romA [256];
  logic [15:0] romB [32];

  assign busA.iInstruction = romA[busA.oIAddress[7:0]];
  assign busB.iInstruction = romB[busB.oIAddress[4:0]];

  mini_alu_pipe dutA (
    .Clock   (Clock),
    .Reset   (ResetA),
    .rom     (busA),
    .oLed    (ledA),
    .oBusy   (busyA),
    .oHalted (haltA)
  );

  mini_alu_pipe #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4),
    .IP_WIDTH(16), .LED_WIDTH(8)
  ) dutB (
    .Clock   (Clock),
    .Reset   (ResetB),
    .rom     (busB),
    .oLed    (ledB),
    .oBusy   (busyB),
    .oHalted (haltB)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] encA(opcode_e op, int d,
                                       int s1, int s0);
    return {op, 8'(d), 8'(s1), 8'(s0)};
  endfunction

  function automatic logic [27:0] stoA(int d, int imm);
    return encA(OP_STO, d, imm >> 8, imm & 255);
  endfunction

  function automatic logic [15:0] encB(opcode_e op, int d,
                                       int s1, int s0);
    return {op, 4'(d), 4'(s1), 4'(s0)};
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic clearA();
    foreach (romA[i]) romA[i] = '0;
  endtask

  task automatic releaseA();
    @(negedge Clock);
    ResetA = 1'b1;
  endtask

  task automatic asyncResetA();
    #2;
    ResetA = 1'b0;
    #1;
  endtask

  int busyCnt, badIp, firstBusy;

  initial begin
    ResetA = 1'b0;
    ResetB = 1'b0;
    clearA();
    foreach (romB[i]) romB[i] = '0;
    #12;
    check("rstLedA", ledA, 0);
    check("rstBusyA", busyA, 0);
    check("rstHaltA", haltA, 0);
    check("rstIpA", busA.oIAddress, 0);
    check("rstIpB", busB.oIAddress, 0);

    // bypass chain: STO, ADD, LED back to back
    romA[0] = stoA(1, 5);
    romA[1] = encA(OP_ADD, 2, 1, 1);
    romA[2] = encA(OP_LED, 0, 2, 0);
    romA[3] = encA(OP_HLT, 0, 0, 0);
    releaseA();
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 3) check("bypLedEarly", ledA, 8'h00);
      if (c == 4) check("bypLed", ledA, 8'h0A);
      if (c == 4) check("bypHaltEarly", haltA, 0);
      if (c == 5) check("bypHalt", haltA, 1);
      if (c == 8) check("bypIpFrozen", busA.oIAddress, 4);
    end
    asyncResetA();
    check("midRstLed", ledA, 0);
    check("midRstHalt", haltA, 0);
    check("midRstIp", busA.oIAddress, 0);

    // counted loop
    clearA();
    romA[0] = stoA(1, 0);
    romA[1] = stoA(2, 1);
    romA[2] = stoA(3, 4);
    romA[3] = encA(OP_ADD, 1, 1, 2);
    romA[4] = encA(OP_BLE, 3, 1, 3);
    romA[5] = encA(OP_LED, 0, 1, 0);
    romA[6] = encA(OP_HLT, 0, 0, 0);
    releaseA();
    for (int c = 1; c <= 22; c++) begin
      step();
      if (c == 6)  check("loopTarget", busA.oIAddress, 3);
      if (c == 18) check("loopLedEarly", ledA, 0);
      if (c == 19) check("loopLed", ledA, 8'h05);
      if (c == 19) check("loopHaltEarly", haltA, 0);
      if (c == 20) check("loopHalt", haltA, 1);
    end
    ResetA = 1'b0;

    // multiply with stall; first run aborted by reset
    clearA();
    romA[0] = stoA(1, 300);
    romA[1] = stoA(2, 7);
    romA[2] = encA(OP_MUL, 3, 1, 2);
    romA[3] = encA(OP_LED, 0, 3, 0);
    romA[4] = encA(OP_HLT, 0, 0, 0);
    releaseA();
    repeat (10) step();
    check("mulBusyMid", busyA, 1);
    asyncResetA();
    check("mulAbortBusy", busyA, 0);
    check("mulAbortIp", busA.oIAddress, 0);
    releaseA();
    #1;
    check("mulRestartIp", busA.oIAddress, 0);
    busyCnt   = 0;
    badIp     = 0;
    firstBusy = 0;
    for (int c = 1; c <= 24; c++) begin
      step();
      if (busyA) begin
        busyCnt++;
        if (firstBusy == 0) firstBusy = c;
        if (busA.oIAddress != 16'd3) badIp++;
      end
      if (c == 20) check("mulLedEarly", ledA, 0);
      if (c == 21) check("mulLed", ledA, 8'h34);
    end
    check("mulBusyCycles", busyCnt, 16);
    check("mulBusyStart", firstBusy, 4);
    check("mulIpStall", badIp, 0);
    check("mulHalt", haltA, 1);
    ResetA = 1'b0;

    // wraparound and shifts
    clearA();
    romA[0]  = stoA(1, 16'hFFFF);
    romA[1]  = stoA(2, 1);
    romA[2]  = encA(OP_ADD, 3, 1, 2);
    romA[3]  = encA(OP_LED, 0, 3, 0);
    romA[4]  = stoA(4, 17);
    romA[5]  = encA(OP_SHL, 5, 2, 4);
    romA[6]  = encA(OP_LED, 0, 5, 0);
    romA[7]  = stoA(6, 16'h8000);
    romA[8]  = stoA(7, 15);
    romA[9]  = encA(OP_SHR, 8, 6, 7);
    romA[10] = encA(OP_LED, 0, 8, 0);
    romA[11] = encA(OP_SUB, 10, 3, 2);
    romA[12] = encA(OP_LED, 0, 10, 0);
    romA[13] = encA(OP_HLT, 0, 0, 0);
    releaseA();
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 7)  check("wrapLed", ledA, 8'h00);
      if (c == 8)  check("shlLed", ledA, 8'h02);
      if (c == 11) check("shlHold", ledA, 8'h02);
      if (c == 12) check("shrLed", ledA, 8'h01);
      if (c == 14) check("subLed", ledA, 8'hFF);
      if (c == 16) check("shiftHalt", haltA, 1);
    end
    ResetA = 1'b0;

    // narrow instance: BEQ, JMP, HLT
    romB[0]  = encB(OP_STO, 1, 0, 3);
    romB[1]  = encB(OP_STO, 2, 0, 4);
    romB[2]  = encB(OP_STO, 3, 0, 3);
    romB[3]  = encB(OP_BEQ, 8, 1, 2);
    romB[4]  = encB(OP_BEQ, 7, 1, 3);
    romB[5]  = encB(OP_LED, 0, 2, 0);
    romB[6]  = encB(OP_HLT, 0, 0, 0);
    romB[7]  = encB(OP_JMP, 15, 0, 0);
    romB[8]  = encB(OP_LED, 0, 2, 0);
    romB[9]  = encB(OP_HLT, 0, 0, 0);
    romB[15] = encB(OP_LED, 0, 1, 0);
    romB[16] = encB(OP_HLT, 0, 0, 0);
    @(negedge Clock);
    ResetB = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      step();
      if (c == 5)  check("beqNotTaken", busB.oIAddress, 5);
      if (c == 6)  check("beqTaken", busB.oIAddress, 7);
      if (c == 8)  check("jmpTarget", busB.oIAddress, 15);
      if (c == 9)  check("jmpLedEarly", ledB, 0);
      if (c == 10) check("jmpLed", ledB, 8'h03);
      if (c == 10) check("hltEarly", haltB, 0);
      if (c >= 11) check("hltFlag", haltB, 1);
      if (c >= 11) check("hltIp", busB.oIAddress, 17);
    end
    check("hltLedHold", ledB, 8'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
